// File: rtl/xtea_port_periph.sv
// xtea_port_periph
//   Port-mapped XTEA engine on the 8-bit PicoBlaze-style port bus.
//   The controller writes a 128-bit key and a 64-bit block one byte at a time.
//   It starts an iterative encrypt or decrypt that runs one full XTEA cycle per
//   clock, then reads the 64-bit result back one byte at a time.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   port_id      port address from the controller
//   write_strobe out_port is valid for port_id this cycle
//   read_strobe  controller consumes in_port this cycle
//   out_port     write data from the controller
//   in_port      read data to the controller (combinational read mux)
//   busy         a run is in progress
//   done         result valid; stays set until a data write or a new start
module xtea_port_periph #(
    parameter logic [7:0]  PORT_KEY    = 8'h30,
    parameter logic [7:0]  PORT_DATA   = 8'h31,
    parameter logic [7:0]  PORT_CTRL   = 8'h33,
    parameter logic [7:0]  PORT_STATUS = 8'h34,
    parameter logic [7:0]  PORT_RESULT = 8'h35,
    parameter int unsigned NUM_CYCLES  = 32,
    parameter logic [31:0] DELTA       = 32'h9E3779B9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       busy,
    output logic       done
);

    localparam int unsigned RW         = $clog2(NUM_CYCLES) + 1;
    localparam logic [RW-1:0] LAST_RND = RW'(NUM_CYCLES - 1);
    // Starting sum for decryption: DELTA * NUM_CYCLES, kept modulo 2^32.
    localparam logic [31:0] SUM_DEC    = DELTA * NUM_CYCLES;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    key_q  [16];
    logic [7:0]    key_d  [16];
    logic [7:0]    data_q [8];
    logic [7:0]    data_d [8];
    logic [7:0]    res_q  [8];
    logic [7:0]    res_d  [8];
    logic [31:0]   v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
    logic [3:0]    key_idx_q, key_idx_d;
    logic [2:0]    data_idx_q, data_idx_d;
    logic [2:0]    rd_idx_q, rd_idx_d;
    logic [RW-1:0] round_q, round_d;
    logic          mode_q, mode_d;

    logic [31:0]   k_w [4];
    logic [31:0]   v0_n, v1_n, sum_n;

    function automatic logic [31:0] f_mix(input logic [31:0] x);
        return ((x << 4) ^ (x >> 5)) + x;
    endfunction

    // Big-endian key words: byte 0 is the top byte of k[0].
    assign k_w[0] = {key_q[0],  key_q[1],  key_q[2],  key_q[3]};
    assign k_w[1] = {key_q[4],  key_q[5],  key_q[6],  key_q[7]};
    assign k_w[2] = {key_q[8],  key_q[9],  key_q[10], key_q[11]};
    assign k_w[3] = {key_q[12], key_q[13], key_q[14], key_q[15]};

    // One complete XTEA cycle: both half-rounds and the sum update together.
    always_comb begin
        v0_n  = v0_q;
        v1_n  = v1_q;
        sum_n = sum_q;
        if (!mode_q) begin
            v0_n  = v0_q + (f_mix(v1_q) ^ (sum_q + k_w[sum_q[1:0]]));
            sum_n = sum_q + DELTA;
            v1_n  = v1_q + (f_mix(v0_n) ^ (sum_n + k_w[sum_n[12:11]]));
        end else begin
            v1_n  = v1_q - (f_mix(v0_q) ^ (sum_q + k_w[sum_q[12:11]]));
            sum_n = sum_q - DELTA;
            v0_n  = v0_q - (f_mix(v1_n) ^ (sum_n + k_w[sum_n[1:0]]));
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        data_d     = data_q;
        res_d      = res_q;
        v0_d       = v0_q;
        v1_d       = v1_q;
        sum_d      = sum_q;
        key_idx_d  = key_idx_q;
        data_idx_d = data_idx_q;
        rd_idx_d   = rd_idx_q;
        round_d    = round_q;
        mode_d     = mode_q;

        if (read_strobe && port_id == PORT_RESULT) begin
            rd_idx_d = rd_idx_q + 3'd1;
        end

        if (write_strobe && port_id == PORT_KEY && state_q != S_RUN) begin
            key_d[key_idx_q] = out_port;
            key_idx_d        = key_idx_q + 4'd1;
        end

        if (write_strobe && port_id == PORT_DATA && state_q != S_RUN) begin
            data_d[data_idx_q] = out_port;
            data_idx_d         = data_idx_q + 3'd1;
            if (state_q == S_DONE) begin
                state_d = S_IDLE;
            end
        end

        if (write_strobe && port_id == PORT_CTRL) begin
            // Pointer clear is applied first so a combined clear+start
            // still gets its start handling below.
            if (out_port[2]) begin
                key_idx_d  = '0;
                data_idx_d = '0;
                rd_idx_d   = '0;
            end
            if (out_port[0] && state_q != S_RUN) begin
                mode_d   = out_port[1];
                v0_d     = {data_q[0], data_q[1], data_q[2], data_q[3]};
                v1_d     = {data_q[4], data_q[5], data_q[6], data_q[7]};
                sum_d    = out_port[1] ? SUM_DEC : '0;
                round_d  = '0;
                rd_idx_d = '0;
                state_d  = S_RUN;
            end
        end

        if (state_q == S_RUN) begin
            v0_d    = v0_n;
            v1_d    = v1_n;
            sum_d   = sum_n;
            round_d = round_q + 1'b1;
            if (round_q == LAST_RND) begin
                {res_d[0], res_d[1], res_d[2], res_d[3]} = v0_n;
                {res_d[4], res_d[5], res_d[6], res_d[7]} = v1_n;
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            key_q      <= '{default: '0};
            data_q     <= '{default: '0};
            res_q      <= '{default: '0};
            v0_q       <= '0;
            v1_q       <= '0;
            sum_q      <= '0;
            key_idx_q  <= '0;
            data_idx_q <= '0;
            rd_idx_q   <= '0;
            round_q    <= '0;
            mode_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            data_q     <= data_d;
            res_q      <= res_d;
            v0_q       <= v0_d;
            v1_q       <= v1_d;
            sum_q      <= sum_d;
            key_idx_q  <= key_idx_d;
            data_idx_q <= data_idx_d;
            rd_idx_q   <= rd_idx_d;
            round_q    <= round_d;
            mode_q     <= mode_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

    always_comb begin
        in_port = '0;
        if (port_id == PORT_STATUS) begin
            in_port = {6'b0, busy, done};
        end else if (port_id == PORT_RESULT) begin
            in_port = res_q[rd_idx_q];
        end
    end

endmodule

// File: tb/tb_xtea_port_periph.sv
// tb_xtea_port_periph
//   Directed bench for xtea_port_periph using the standard XTEA vector.
//   The key is 000102..0F, the plaintext is "ABCDEFGH" and the ciphertext is
//   497DF3D0 72612CB5.
//   Inputs change just after the falling edge. in_port is sampled before the
//   rising edge on which the read strobe is consumed.
module tb_xtea_port_periph;

    localparam logic [7:0] P_KEY = 8'h30;
    localparam logic [7:0] P_DAT = 8'h31;
    localparam logic [7:0] P_CTL = 8'h33;
    localparam logic [7:0] P_STA = 8'h34;
    localparam logic [7:0] P_RES = 8'h35;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] port_id = '0;
    logic       write_strobe = 1'b0;
    logic       read_strobe = 1'b0;
    logic [7:0] out_port = '0;
    logic [7:0] in_port;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0] PT [8] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
    logic [7:0] CT [8] = '{8'h49, 8'h7D, 8'hF3, 8'hD0, 8'h72, 8'h61, 8'h2C, 8'hB5};

    typedef enum logic [1:0] {OP_WR, OP_RD, OP_WAIT} kind_t;
    typedef struct {
        kind_t      kind;
        logic [7:0] port;
        logic [7:0] val;
        string      name;
    } op_t;
    op_t ops[$];

    xtea_port_periph #(
        .PORT_KEY   (8'h30),
        .PORT_DATA  (8'h31),
        .PORT_CTRL  (8'h33),
        .PORT_STATUS(8'h34),
        .PORT_RESULT(8'h35),
        .NUM_CYCLES (32),
        .DELTA      (32'h9E3779B9)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .port_id     (port_id),
        .write_strobe(write_strobe),
        .read_strobe (read_strobe),
        .out_port    (out_port),
        .in_port     (in_port),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] v);
        port_id      = p;
        out_port     = v;
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] p, output logic [7:0] v);
        port_id     = p;
        read_strobe = 1'b1;
        #1 v = in_port;
        @(negedge clk);
        read_strobe = 1'b0;
    endtask

    task automatic rd_chk(input logic [7:0] p, input logic [7:0] exp, input string name);
        logic [7:0] v;
        rd(p, v);
        check(name, {24'b0, v}, {24'b0, exp});
    endtask

    // Entered start_c cycles after the edge that accepted the start. Done must
    // first be seen 33 cycles after the start, with busy high before that.
    task automatic wait_done(input string name, input int start_c);
        int done_at = 0;
        int busy_cnt = 0;
        for (int c = start_c; c <= 200; c++) begin
            if (done) begin
                done_at = c;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check({name, "_done_cycle"}, done_at, 33);
        check({name, "_busy_cycles"}, busy_cnt, 33 - start_c);
    endtask

    task automatic add(input kind_t k, input logic [7:0] p, input logic [7:0] v, input string n);
        ops.push_back('{kind: k, port: p, val: v, name: n});
    endtask

    task automatic add_key();
        for (int i = 0; i < 16; i++) add(OP_WR, P_KEY, 8'(i), "");
    endtask

    task automatic add_data(input logic [7:0] b [8]);
        for (int i = 0; i < 8; i++) add(OP_WR, P_DAT, b[i], "");
    endtask

    task automatic add_reads(input logic [7:0] b [8], input string n);
        for (int i = 0; i < 8; i++) add(OP_RD, P_RES, b[i], $sformatf("%s_byte%0d", n, i));
    endtask

    task automatic run_ops();
        logic [7:0] v;
        foreach (ops[i]) begin
            case (ops[i].kind)
                OP_WR:   wr(ops[i].port, ops[i].val);
                OP_RD: begin
                    rd(ops[i].port, v);
                    check(ops[i].name, {24'b0, v}, {24'b0, ops[i].val});
                end
                default: wait_done(ops[i].name, 1);
            endcase
        end
        ops.delete();
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_done", {31'b0, done}, 0);
        port_id = P_STA;
        #1 check("reset_status", {24'b0, in_port}, 0);
        port_id = P_RES;
        #1 check("reset_result", {24'b0, in_port}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Encrypt
        add_key();
        add_data(PT);
        add(OP_WR, P_CTL, 8'h01, "");
        add(OP_WAIT, 8'h00, 8'h00, "enc");
        add(OP_RD, P_STA, 8'h01, "enc_status");
        add_reads(CT, "enc");
        run_ops();

        // Decrypt round trip (key still loaded)
        add_data(CT);
        add(OP_WR, P_CTL, 8'h03, "");
        add(OP_WAIT, 8'h00, 8'h00, "dec");
        add(OP_RD, P_STA, 8'h01, "dec_status");
        add_reads(PT, "dec");
        run_ops();

        // Writes while busy are ignored and do not move the pointers
        add_data(PT);
        run_ops();
        wr(P_CTL, 8'h01);
        check("busy_after_start", {31'b0, busy}, 1);
        wr(P_KEY, 8'hFF);
        wr(P_DAT, 8'hFF);
        wr(P_CTL, 8'h01);
        wait_done("busyprot", 4);
        add_reads(CT, "busyprot");
        add_data(CT);
        add(OP_WR, P_CTL, 8'h03, "");
        add(OP_WAIT, 8'h00, 8'h00, "busyprot_dec");
        add_reads(PT, "busyprot_dec");
        run_ops();

        // Key pointer wrap, pointer clear, combined clear+start, read wrap
        add_key();
        add(OP_WR, P_KEY, 8'hEE, "");
        add(OP_WR, P_CTL, 8'h04, "");
        add_key();
        add_data(PT);
        add(OP_WR, P_CTL, 8'h05, "");
        add(OP_WAIT, 8'h00, 8'h00, "wrap");
        add_reads(CT, "wrap");
        add(OP_RD, P_RES, CT[0], "wrap_ninth_read");
        run_ops();

        // Reset in the middle of a run
        wr(P_CTL, 8'h01);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midreset_busy", {31'b0, busy}, 0);
        check("midreset_done", {31'b0, done}, 0);
        rd_chk(P_STA, 8'h00, "midreset_status");
        rd_chk(P_RES, 8'h00, "midreset_res0");
        rd_chk(P_RES, 8'h00, "midreset_res1");
        repeat (40) @(negedge clk);
        check("midreset_no_done", {31'b0, done}, 0);
        add_key();
        add_data(PT);
        add(OP_WR, P_CTL, 8'h01, "");
        add(OP_WAIT, 8'h00, 8'h00, "postreset");
        add_reads(CT, "postreset");
        run_ops();

        // Unmapped port, data write after DONE, stale result reads
        rd_chk(8'h50, 8'h00, "unmapped");
        wr(P_DAT, 8'h41);
        check("datawr_done", {31'b0, done}, 0);
        rd_chk(P_STA, 8'h00, "datawr_status");
        rd_chk(8'h50, 8'h00, "unmapped_again");
        rd_chk(P_RES, CT[0], "stale_byte0");
        rd_chk(P_RES, CT[1], "stale_byte1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
